// File: rtl/pwm_peripheral_if.sv
// Configuration bytes from the SPI register-write stage (SCLK domain) into the PWM block.
interface pwm_peripheral_if;
   logic [7:0] en_reg_out_7_0;
   logic [7:0] en_reg_out_15_8;
   logic [7:0] en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8;
   logic [7:0] pwm_duty_cycle;

   modport master (
      output en_reg_out_7_0, en_reg_out_15_8,
      output en_reg_pwm_7_0, en_reg_pwm_15_8,
      output pwm_duty_cycle
   );

   modport slave (
      input en_reg_out_7_0, en_reg_out_15_8,
      input en_reg_pwm_7_0, en_reg_pwm_15_8,
      input pwm_duty_cycle
   );
endinterface

// File: rtl/pwm_peripheral.sv
// Drives 16 outputs as static high, static low or a shared 8-bit PWM waveform,
// with SPI-domain configuration synchronized into the system clock domain.
module pwm_peripheral #(
   parameter int unsigned CLK_DIV = 3000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pwm_peripheral_if.slave        cfg,
   output logic [15:0]            out
);
   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   logic [15:0] en_out_meta, en_out_s;
   logic [15:0] en_pwm_meta, en_pwm_s;
   logic [7:0]  duty_meta, duty_s, duty_prev;
   logic [7:0]  duty_shadow;
   logic [7:0]  pwm_cnt;
   logic [15:0] prescaler;
   logic        tick, boundary, duty_ok, pwm_hi;
   logic [15:0] out_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_out_meta <= '0;
         en_out_s    <= '0;
         en_pwm_meta <= '0;
         en_pwm_s    <= '0;
         duty_meta   <= '0;
         duty_s      <= '0;
         duty_prev   <= '0;
      end else begin
         en_out_meta <= {cfg.en_reg_out_15_8, cfg.en_reg_out_7_0};
         en_out_s    <= en_out_meta;
         en_pwm_meta <= {cfg.en_reg_pwm_15_8, cfg.en_reg_pwm_7_0};
         en_pwm_s    <= en_pwm_meta;
         duty_meta   <= cfg.pwm_duty_cycle;
         duty_s      <= duty_meta;
         duty_prev   <= duty_s;
      end
   end

   always_comb begin
      tick     = (prescaler == DIV_LAST);
      boundary = tick && (pwm_cnt == 8'hFF);
      // Two equal consecutive samples mean the multi-bit duty was not caught mid-change.
      duty_ok  = (duty_s == duty_prev);
      pwm_hi   = (duty_shadow == 8'hFF) || (pwm_cnt < duty_shadow);
      out_next = en_out_s & (~en_pwm_s | {16{pwm_hi}});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler   <= '0;
         pwm_cnt     <= '0;
         duty_shadow <= '0;
         out         <= '0;
      end else begin
         prescaler <= tick ? '0 : prescaler + 16'd1;
         if (tick)
            pwm_cnt <= pwm_cnt + 8'd1;
         if (boundary && duty_ok)
            duty_shadow <= duty_s;
         out <= out_next;
      end
   end
endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral with CLK_DIV=4 (1024-clock PWM period).
module tb_pwm_peripheral;
   logic        clk;
   logic        rst_n;
   logic [15:0] out;
   int          vectors;
   int          miscompares;
   int          shape_bad;
   int          n, hi, lo, rest, first_rise, bad;
   logic [15:0] out_k2, out_k3;

   pwm_peripheral_if cfg ();

   pwm_peripheral #(.CLK_DIV(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cfg   (cfg),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h (%0d) expected %0h (%0d)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
      cfg.en_reg_out_7_0  = eo[7:0];
      cfg.en_reg_out_15_8 = eo[15:8];
      cfg.en_reg_pwm_7_0  = ep[7:0];
      cfg.en_reg_pwm_15_8 = ep[15:8];
      cfg.pwm_duty_cycle  = d;
   endtask

   // Used only while en_out=FFFF, en_pwm=00FF: static byte high, PWM byte uniform.
   task automatic shape_check();
      if (out[15:8] !== 8'hFF || (out[7:0] !== 8'h00 && out[7:0] !== 8'hFF))
         shape_bad++;
   endtask

   // Steps until out[0] goes 0->1; returns steps taken, or -1 on timeout.
   task automatic wait_rise(output int steps);
      logic prev;
      prev  = out[0];
      steps = -1;
      for (int i = 1; i <= 2200; i++) begin
         step();
         shape_check();
         if (!prev && out[0] === 1'b1) begin
            steps = i;
            return;
         end
         prev = out[0];
      end
   endtask

   // Counts consecutive high samples of out[0] starting at the current one.
   task automatic count_high(output int cnt);
      cnt = 0;
      for (int i = 0; i < 2100; i++) begin
         if (out[0] !== 1'b1)
            return;
         cnt++;
         step();
         shape_check();
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      shape_bad   = 0;
      rst_n       = 1'b1;
      set_cfg(16'h0000, 16'h0000, 8'h00);

      // Reset takes effect without a clock edge
      #2 rst_n = 1'b0;
      #1 check("reset_async", out, 16'h0000);
      step();
      step();
      check("reset_held", out, 16'h0000);
      rst_n = 1'b1;

      // Idle with all inputs zero
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         step();
         if (out !== 16'h0000)
            bad++;
      end
      check("idle_zero", bad, 0);

      // Enable path latency: visible on the 3rd edge
      set_cfg(16'hA55A, 16'h0000, 8'h00);
      step();
      check("en_lat_1", out, 16'h0000);
      step();
      check("en_lat_2", out, 16'h0000);
      step();
      check("en_lat_3", out, 16'hA55A);

      // Static high byte plus PWM byte at duty 0x80
      set_cfg(16'hFFFF, 16'h00FF, 8'h80);
      step();
      step();
      step();
      check("mix_static", out, 16'hFF00);
      wait_rise(n);
      count_high(hi);
      check("d80_high", hi, 512);
      wait_rise(lo);
      check("d80_low", lo, 512);

      // Duty 0: PWM bits low across 3 periods
      set_cfg(16'hFFFF, 16'h00FF, 8'h00);
      for (int i = 0; i < 1100; i++) step();
      bad = 0;
      for (int i = 0; i < 3072; i++) begin
         step();
         if (out !== 16'hFF00)
            bad++;
      end
      check("d00_const_low", bad, 0);

      // Duty 0xFF: PWM bits high across 3 periods
      set_cfg(16'hFFFF, 16'h00FF, 8'hFF);
      for (int i = 0; i < 1100; i++) step();
      bad = 0;
      for (int i = 0; i < 3072; i++) begin
         step();
         if (out !== 16'hFFFF)
            bad++;
      end
      check("dff_const_high", bad, 0);

      // Duty 0x40 steady state
      set_cfg(16'hFFFF, 16'h00FF, 8'h40);
      for (int i = 0; i < 1100; i++) step();
      wait_rise(n);
      count_high(hi);
      check("d40_high", hi, 256);
      wait_rise(lo);
      check("d40_low", lo, 768);

      // Change 0x40 -> 0xC0 100 clks into the high phase
      for (int i = 0; i < 100; i++) begin
         step();
         shape_check();
      end
      set_cfg(16'hFFFF, 16'h00FF, 8'hC0);
      count_high(rest);
      check("chg_cur_high", 100 + rest, 256);
      wait_rise(lo);
      check("chg_cur_low", lo, 768);
      count_high(hi);
      check("chg_next_high", hi, 768);
      wait_rise(lo);
      check("chg_next_low", lo, 256);

      // Reset pulse mid high phase
      for (int i = 0; i < 50; i++) step();
      check("pre_reset_high", out, 16'hFFFF);
      rst_n = 1'b0;
      #1 check("mid_reset_async", out, 16'h0000);
      step();
      step();
      rst_n = 1'b1;
      first_rise = -1;
      out_k2     = 'x;
      out_k3     = 'x;
      for (int k = 1; k <= 1100; k++) begin
         step();
         if (k == 2) out_k2 = out;
         if (k == 3) out_k3 = out;
         if (out[0] === 1'b1) begin
            first_rise = k;
            break;
         end
      end
      check("post_rst_k2", out_k2, 16'h0000);
      check("post_rst_k3", out_k3, 16'hFF00);
      check("post_rst_first_rise", first_rise, 1025);
      count_high(hi);
      check("post_rst_high", hi, 768);

      check("waveform_shape", shape_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
